// File: rtl/ls_exec_unit.sv
// Load/store execution unit: one in-order memory op at a time. Computes the
// effective address, runs a req/ack data-memory access, then arbitrates for
// the CDB to broadcast the result. Recovery can squash the op in flight.
module ls_exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [5:0]        p_rd_in,
  input  logic [3:0]        rob_num_in,
  input  logic              RegDest_in,
  input  logic              mem_ren_in,
  input  logic              mem_wen_in,
  input  logic [15:0]       immed_in,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              recover,
  input  logic [3:0]        rob_num_rec,
  output logic              lsu_busy,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              cdb_req,
  input  logic              cdb_gnt,
  output logic              complete,
  output logic [5:0]        p_rd_compl,
  output logic              RegDest_compl,
  output logic [3:0]        rob_num_compl,
  output logic [DATA_W-1:0] result_data
);

  typedef enum logic [1:0] {StIdle, StMem, StCdb} state_e;

  state_e            state_q, state_d;
  logic              squash_q, squash_d;
  logic [5:0]        p_rd_q, p_rd_d;
  logic [3:0]        rob_q, rob_d;
  logic              regdest_q, regdest_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              kill;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] eff_addr;

  // Recovery only matters for the op actually held here.
  assign kill     = recover && (rob_num_rec == rob_q) && (state_q != StIdle);
  assign imm_sext = ADDR_W'($signed(immed_in));
  assign eff_addr = ADDR_W'(rs_data) + imm_sext;

  // State and latched op fields; async reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      squash_q  <= 1'b0;
      p_rd_q    <= '0;
      rob_q     <= '0;
      regdest_q <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      squash_q  <= squash_d;
      p_rd_q    <= p_rd_d;
      rob_q     <= rob_d;
      regdest_q <= regdest_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state: accept in IDLE, finish the handshake in MEM, broadcast in CDB.
  always_comb begin
    state_d   = state_q;
    squash_d  = squash_q;
    p_rd_d    = p_rd_q;
    rob_d     = rob_q;
    regdest_d = regdest_q;
    load_d    = load_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (issue && !recover && (mem_ren_in || mem_wen_in)) begin
          p_rd_d    = p_rd_in;
          rob_d     = rob_num_in;
          regdest_d = RegDest_in;
          load_d    = mem_ren_in;
          addr_d    = eff_addr;
          wdata_d   = rt_data;
          rdata_d   = '0;
          squash_d  = 1'b0;
          state_d   = StMem;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          rdata_d  = load_q ? dmem_rdata : '0;
          squash_d = 1'b0;
          // The request is never dropped mid-handshake; a squash only
          // suppresses the broadcast.
          state_d  = (squash_q || kill) ? StIdle : StCdb;
        end else if (kill) begin
          squash_d = 1'b1;
        end
      end
      StCdb: begin
        if (kill || cdb_gnt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; broadcast fields zero outside CDB.
  always_comb begin
    lsu_busy      = (state_q != StIdle);
    dmem_req      = (state_q == StMem);
    dmem_we       = (state_q == StMem) && !load_q;
    dmem_addr     = addr_q;
    dmem_wdata    = wdata_q;
    cdb_req       = (state_q == StCdb);
    complete      = cdb_req && cdb_gnt && !kill;
    p_rd_compl    = '0;
    RegDest_compl = 1'b0;
    rob_num_compl = '0;
    result_data   = '0;
    if (state_q == StCdb) begin
      p_rd_compl    = p_rd_q;
      RegDest_compl = regdest_q && load_q;
      rob_num_compl = rob_q;
      result_data   = rdata_q;
    end
  end

  // Station must honour lsu_busy.
  a_no_issue_when_busy: assert property (@(posedge clk) disable iff (!rst) !(issue && lsu_busy));

endmodule
